// File: rtl/sram16_responder_if.sv
// CPU-side 32-bit read/write/waitrequest bus between the fabric and the SRAM responder.
interface sram16_responder_if #(
    parameter int unsigned ADDR_WIDTH = 18
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [31:0]           writedata;
    logic [3:0]            byteenable;
    logic [31:0]           readdata;
    logic                  waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/sram16_responder.sv
// Serves each 32-bit bus word as two 16-bit async SRAM cycles (high half first),
// skipping write halves with no enabled bytes. waitrequest stays high until DONE.
module sram16_responder #(
    parameter int unsigned ADDR_WIDTH  = 18,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    sram16_responder_if.slave   bus,
    output logic [ADDR_WIDTH:0] sram_addr,
    output logic [15:0]         sram_dq_out,
    input  logic [15:0]         sram_dq_in,
    output logic                sram_dq_oe,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic                sram_ub_n,
    output logic                sram_lb_n
);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

    state_e              state_q, state_d;
    logic                phase_q, phase_d;     // 0 = high halfword, 1 = low halfword
    logic [3:0]          cnt_q, cnt_d;
    logic                op_write_q, op_write_d;
    logic [3:0]          be_q;
    logic [ADDR_WIDTH:0] addr_q;
    logic [15:0]         dq_q;
    logic [31:0]         readdata_q;
    logic                load;                 // sample bus inputs on SETUP entry
    logic                capture;              // last STROBE edge of a read
    logic [1:0]          half_be;

    assign half_be          = phase_q ? be_q[1:0] : be_q[3:2];
    assign bus.readdata     = readdata_q;
    assign bus.waitrequest  = (bus.read | bus.write) & (state_q != StDone);
    assign sram_addr        = addr_q;
    assign sram_dq_out      = dq_q;

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            phase_q    <= 1'b0;
            cnt_q      <= 4'd0;
            op_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
        end
    end

    // Next-state logic; write takes priority over read when both are requested.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        load       = 1'b0;
        capture    = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.write) begin
                    op_write_d = 1'b1;
                    if (|bus.byteenable) begin
                        state_d = StSetup;
                        phase_d = ~|bus.byteenable[3:2];
                        load    = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end else if (bus.read) begin
                    op_write_d = 1'b0;
                    state_d    = StSetup;
                    phase_d    = 1'b0;
                    load       = 1'b1;
                end
            end
            StSetup: begin
                state_d = StStrobe;
                cnt_d   = WAIT_CYCLES[3:0];
            end
            StStrobe: begin
                if (cnt_q <= 4'd1) begin
                    state_d = StHold;
                    capture = ~op_write_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                // Reads always do the low half; writes only if a low byte is enabled.
                if (!phase_q && (!op_write_q || (|be_q[1:0]))) begin
                    state_d = StSetup;
                    phase_d = 1'b1;
                    load    = 1'b1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // SRAM pin decode from the registered state only, so strobes never glitch on bus inputs.
    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_ub_n  = 1'b1;
        sram_lb_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (state_q)
            StSetup, StHold: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = op_write_q;
            end
            StStrobe: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = op_write_q;
                if (op_write_q) begin
                    sram_we_n = 1'b0;
                    sram_ub_n = ~half_be[1];
                    sram_lb_n = ~half_be[0];
                end else begin
                    sram_oe_n = 1'b0;
                    sram_ub_n = 1'b0;
                    sram_lb_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath: address/data latched per halfword, read halves captured at end of STROBE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            be_q       <= 4'd0;
            addr_q     <= '0;
            dq_q       <= 16'd0;
            readdata_q <= 32'd0;
        end else begin
            if (load) begin
                be_q   <= bus.byteenable;
                addr_q <= {bus.address, phase_d};
                dq_q   <= phase_d ? bus.writedata[15:0] : bus.writedata[31:16];
            end
            if (capture) begin
                if (phase_q) begin
                    readdata_q[15:0] <= sram_dq_in;
                end else begin
                    readdata_q[31:16] <= sram_dq_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram16_responder.sv
// Directed bench for sram16_responder with a behavioural async SRAM model.
module tb_sram16_responder;

    localparam int unsigned AW = 18;

    typedef logic [15:0] mem_t [0:255];

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < 256; i++) m[i] = 16'h5A5A;
        m[32] = 16'h1234;
        m[33] = 16'hABCD;
        return m;
    endfunction

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW:0]   sram_addr;
    logic [15:0]   sram_dq_out;
    logic [15:0]   sram_dq_in;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    mem_t mem = init_mem();
    int   ce_low_total  = 0;
    int   we_low_total  = 0;
    int   we_pulse_total = 0;
    int   ub_w_total    = 0;
    int   lb_w_total    = 0;
    int   oe_bad_total  = 0;
    logic we_prev       = 1'b1;

    int checks = 0;
    int errors = 0;

    sram16_responder_if #(.ADDR_WIDTH(AW)) bus_if ();

    sram16_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus_if),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .sram_ub_n   (sram_ub_n),
        .sram_lb_n   (sram_lb_n)
    );

    always #5 clk = ~clk;

    // SRAM read path: data only while selected and output-enabled.
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'hFFFF;

    // SRAM write model and strobe activity counters.
    always @(posedge clk) begin
        if (!sram_ce_n) ce_low_total++;
        if (!sram_ce_n && !sram_we_n) begin
            we_low_total++;
            if (!sram_dq_oe) oe_bad_total++;
            if (!sram_ub_n) begin
                ub_w_total++;
                mem[sram_addr[7:0]][15:8] = sram_dq_out[15:8];
            end
            if (!sram_lb_n) begin
                lb_w_total++;
                mem[sram_addr[7:0]][7:0] = sram_dq_out[7:0];
            end
        end
        if (we_prev && !sram_we_n) we_pulse_total++;
        we_prev = sram_we_n;
    end

    task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        bus_if.read       = rd;
        bus_if.write      = wr;
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.byteenable = be;
    endtask

    // Count cycles (negedge samples) until waitrequest drops; -1 on timeout.
    task automatic wait_accept(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus_if.waitrequest && cyc < 40);
        if (bus_if.waitrequest) cyc = -1;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          output int cyc, output logic [31:0] rdata);
        @(posedge clk); #1;
        drive(rd, wr, a, d, be);
        wait_accept(cyc);
        rdata = bus_if.readdata;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, 32'd0, 4'd0);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, '0, 32'd0, 4'd0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
            errors++;
            $display("FAIL reset_strobes got %b want 11111",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
        end
        checks++;
        if (bus_if.readdata !== 32'd0 || sram_dq_oe !== 1'b0 || bus_if.waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs rd=%h oe=%b wr=%b want 0 0 0",
                     bus_if.readdata, sram_dq_oe, bus_if.waitrequest);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_read();
        int cyc;
        logic [31:0] rd;
        access(1'b1, 1'b0, 18'h00010, 32'd0, 4'b0000, cyc, rd);
        checks++;
        if (rd !== 32'h1234ABCD) begin
            errors++;
            $display("FAIL read_data got %h want 1234abcd", rd);
        end
        checks++;
        if (cyc !== 10) begin
            errors++;
            $display("FAIL read_latency got %0d want 10", cyc);
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 18'h00010, 32'd0, 4'b0000);
        wait_accept(c1);
        @(posedge clk); #1;
        wait_accept(c2);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, 32'd0, 4'd0);
        checks++;
        if (c1 !== 10 || c2 !== 10) begin
            errors++;
            $display("FAIL back_to_back got %0d,%0d want 10,10", c1, c2);
        end
    endtask

    task automatic test_write_full();
        int cyc, p0, w0;
        logic [31:0] rd;
        p0 = we_pulse_total;
        w0 = we_low_total;
        access(1'b0, 1'b1, 18'h00005, 32'hDEADBEEF, 4'b1111, cyc, rd);
        checks++;
        if (mem[10] !== 16'hDEAD || mem[11] !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_full_mem got %h %h want dead beef", mem[10], mem[11]);
        end
        checks++;
        if (we_pulse_total - p0 !== 2 || we_low_total - w0 !== 4) begin
            errors++;
            $display("FAIL write_full_we got pulses=%0d low=%0d want 2 4",
                     we_pulse_total - p0, we_low_total - w0);
        end
        checks++;
        if (cyc !== 10) begin
            errors++;
            $display("FAIL write_full_latency got %0d want 10", cyc);
        end
    endtask

    task automatic test_write_low_byte();
        int cyc, ub0, lb0, p0;
        logic [31:0] rd;
        ub0 = ub_w_total;
        lb0 = lb_w_total;
        p0  = we_pulse_total;
        access(1'b0, 1'b1, 18'h00000, 32'h000000A5, 4'b0001, cyc, rd);
        checks++;
        if (mem[1] !== 16'h5AA5 || mem[0] !== 16'h5A5A) begin
            errors++;
            $display("FAIL write_byte_mem got %h %h want 5a5a 5aa5", mem[0], mem[1]);
        end
        checks++;
        if (ub_w_total - ub0 !== 0 || lb_w_total - lb0 !== 2 || we_pulse_total - p0 !== 1) begin
            errors++;
            $display("FAIL write_byte_lanes got ub=%0d lb=%0d pulses=%0d want 0 2 1",
                     ub_w_total - ub0, lb_w_total - lb0, we_pulse_total - p0);
        end
        checks++;
        if (cyc !== 6) begin
            errors++;
            $display("FAIL write_byte_latency got %0d want 6", cyc);
        end
    endtask

    task automatic test_write_high_half();
        int cyc;
        logic [31:0] rd;
        access(1'b0, 1'b1, 18'h00008, 32'hCAFE1111, 4'b1100, cyc, rd);
        checks++;
        if (mem[16] !== 16'hCAFE || mem[17] !== 16'h5A5A || cyc !== 6) begin
            errors++;
            $display("FAIL write_high got %h %h cyc=%0d want cafe 5a5a 6", mem[16], mem[17], cyc);
        end
    endtask

    task automatic test_write_no_bytes();
        int cyc, c0;
        logic [31:0] rd;
        c0 = ce_low_total;
        access(1'b0, 1'b1, 18'h00002, 32'hFFFFFFFF, 4'b0000, cyc, rd);
        checks++;
        if (cyc !== 2 || ce_low_total - c0 !== 0) begin
            errors++;
            $display("FAIL write_be0 got cyc=%0d ce_cycles=%0d want 2 0", cyc, ce_low_total - c0);
        end
    endtask

    task automatic test_read_write_both();
        int cyc;
        logic [31:0] rd;
        access(1'b1, 1'b1, 18'h00003, 32'h11223344, 4'b1111, cyc, rd);
        checks++;
        if (mem[6] !== 16'h1122 || mem[7] !== 16'h3344 || cyc !== 10) begin
            errors++;
            $display("FAIL rw_both_write got %h %h cyc=%0d want 1122 3344 10", mem[6], mem[7], cyc);
        end
        checks++;
        if (rd !== 32'h1234ABCD) begin
            errors++;
            $display("FAIL rw_both_readdata got %h want 1234abcd", rd);
        end
    endtask

    task automatic test_reset_mid_read();
        int cyc, c0;
        logic [31:0] rd;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 18'h00010, 32'd0, 4'b0000);
        repeat (3) @(negedge clk);
        checks++;
        if (sram_oe_n !== 1'b0) begin
            errors++;
            $display("FAIL mid_read_in_strobe got oe_n=%b want 0", sram_oe_n);
        end
        reset_n = 1'b0;
        drive(1'b0, 1'b0, '0, 32'd0, 4'd0);
        @(posedge clk); #1;
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111
            || sram_dq_oe !== 1'b0 || sram_addr !== '0) begin
            errors++;
            $display("FAIL mid_reset_pins got %b oe=%b addr=%h want 11111 0 0",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, sram_dq_oe, sram_addr);
        end
        checks++;
        if (bus_if.readdata !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_readdata got %h want 0", bus_if.readdata);
        end
        c0 = ce_low_total;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        checks++;
        if (ce_low_total - c0 !== 0) begin
            errors++;
            $display("FAIL mid_reset_no_strobes got ce_cycles=%0d want 0", ce_low_total - c0);
        end
        access(1'b1, 1'b0, 18'h00010, 32'd0, 4'b0000, cyc, rd);
        checks++;
        if (rd !== 32'h1234ABCD || cyc !== 10) begin
            errors++;
            $display("FAIL read_after_reset got %h cyc=%0d want 1234abcd 10", rd, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_back_to_back();
        test_write_full();
        test_write_low_byte();
        test_write_high_half();
        test_write_no_bytes();
        test_read_write_both();
        test_reset_mid_read();
        checks++;
        if (oe_bad_total !== 0) begin
            errors++;
            $display("FAIL dq_oe_during_write got %0d undriven write cycles want 0", oe_bad_total);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
